// File: rtl/i2si_pkg.sv
// Shared types and constants for the I2S frame receiver.
package i2si_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2si_frame_rx_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with a registered rising-edge pulse.
module i2si_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  assign level = chain[SYNC_STAGES-1];

  // synchroniser chain, previous-level register and edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/i2si_frame_rx.sv
// I2S / left-justified stereo receiver: oversampled pins, WS-tracked slots,
// one aligned L/R pair per frame with transfer strobe and short-slot error.
module i2si_frame_rx #(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_i2si_en,
  input  logic              rf_i2si_mode,
  input  logic              i2si_sck,
  input  logic              i2si_ws,
  input  logic              i2si_sd,
  output logic [DATA_W-1:0] i2si_lft,
  output logic [DATA_W-1:0] i2si_rgt,
  output logic              i2si_xfc,
  output logic              i2si_err,
  output logic              i2si_active
);
  import i2si_pkg::*;

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

  logic sck_rise;
  logic ws_lvl;
  logic sd_lvl;
  logic unused_sck_lvl;
  logic unused_ws_rise;
  logic unused_sd_rise;

  i2si_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst(rst), .din(i2si_sck), .level(unused_sck_lvl), .rise(sck_rise)
  );
  i2si_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ws (
    .clk(clk), .rst(rst), .din(i2si_ws), .level(ws_lvl), .rise(unused_ws_rise)
  );
  i2si_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sd (
    .clk(clk), .rst(rst), .din(i2si_sd), .level(sd_lvl), .rise(unused_sd_rise)
  );

  state_t            state;
  logic              mode_r;
  logic              ws_prev;
  logic              prev_ch;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] pend_l;

  logic              cur_ch;
  logic              boundary;
  logic              short_slot;
  logic [DATA_W-1:0] first_word;
  logic [DATA_W-1:0] shifted;

  // channel of the incoming bit and the slot word it would produce
  always_comb begin
    cur_ch     = (mode_r == MODE_LJ) ? ws_lvl : ws_prev;
    boundary   = (cur_ch != prev_ch);
    short_slot = (cnt < CNT_FULL);
    first_word = sd_lvl ? MSB_ONE : '0;
    if (cnt < CNT_FULL) begin
      shifted = shreg | (sd_lvl ? (MSB_ONE >> cnt) : '0);
    end else begin
      shifted = shreg;
    end
  end

  // receiver state machine, slot assembly and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_r      <= MODE_I2S;
      ws_prev     <= 1'b0;
      prev_ch     <= CH_LEFT;
      cnt         <= '0;
      shreg       <= '0;
      pend_l      <= '0;
      i2si_lft    <= '0;
      i2si_rgt    <= '0;
      i2si_xfc    <= 1'b0;
      i2si_err    <= 1'b0;
      i2si_active <= 1'b0;
    end else begin
      i2si_xfc <= 1'b0;
      i2si_err <= 1'b0;
      if (sck_rise) begin
        ws_prev <= ws_lvl;
      end
      if (!rf_i2si_en) begin
        state       <= IDLE;
        mode_r      <= rf_i2si_mode;
        prev_ch     <= CH_LEFT;
        cnt         <= '0;
        shreg       <= '0;
        pend_l      <= '0;
        i2si_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            mode_r  <= rf_i2si_mode;
            prev_ch <= CH_LEFT;
            state   <= SYNC;
          end
          SYNC: begin
            if (sck_rise) begin
              prev_ch <= cur_ch;
              // lock only on a right->left edge so the first pair is complete
              if (boundary && (cur_ch == CH_LEFT)) begin
                state       <= RUN;
                i2si_active <= 1'b1;
                shreg       <= first_word;
                cnt         <= CNT_ONE;
              end
            end
          end
          RUN: begin
            if (sck_rise) begin
              prev_ch <= cur_ch;
              if (boundary) begin
                i2si_err <= short_slot;
                if (prev_ch == CH_LEFT) begin
                  pend_l <= shreg;
                end else begin
                  i2si_lft <= pend_l;
                  i2si_rgt <= shreg;
                  i2si_xfc <= 1'b1;
                end
                shreg <= first_word;
                cnt   <= CNT_ONE;
              end else begin
                shreg <= shifted;
                if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_ONE;
                end
              end
            end
          end
          default: begin
            state       <= IDLE;
            i2si_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2si_frame_rx.sv
// Directed bench for i2si_frame_rx: a 16-bit and a 24-bit receiver share the same pins.
module tb_i2si_frame_rx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        sck;
  logic        ws;
  logic        sd;
  logic [15:0] lft16, rgt16;
  logic [23:0] lft24, rgt24;
  logic        xfc16, err16, act16;
  logic        xfc24, err24, act24;

  i2si_frame_rx #(.DATA_W(16), .CNT_W(6), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .rf_i2si_en(en), .rf_i2si_mode(mode),
    .i2si_sck(sck), .i2si_ws(ws), .i2si_sd(sd),
    .i2si_lft(lft16), .i2si_rgt(rgt16), .i2si_xfc(xfc16), .i2si_err(err16),
    .i2si_active(act16)
  );

  i2si_frame_rx #(.DATA_W(24), .CNT_W(6), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst(rst), .rf_i2si_en(en), .rf_i2si_mode(mode),
    .i2si_sck(sck), .i2si_ws(ws), .i2si_sd(sd),
    .i2si_lft(lft24), .i2si_rgt(rgt24), .i2si_xfc(xfc24), .i2si_err(err24),
    .i2si_active(act24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   xfc16_n = 0, err16_n = 0, both16_n = 0, xfc24_n = 0, err24_n = 0, consec_n = 0;
  logic xfc16_q = 1'b0, xfc24_q = 1'b0;

  // pulse counters sampled on the falling edge
  always @(negedge clk) begin
    xfc16_n  <= xfc16_n + int'(xfc16);
    err16_n  <= err16_n + int'(err16);
    both16_n <= both16_n + int'(xfc16 & err16);
    xfc24_n  <= xfc24_n + int'(xfc24);
    err24_n  <= err24_n + int'(err24);
    consec_n <= consec_n + int'(xfc16 & xfc16_q) + int'(xfc24 & xfc24_q);
    xfc16_q  <= xfc16;
    xfc24_q  <= xfc24;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one SCK period = 8 clk; ws/sd change while sck is low
  task automatic send_bit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    #40;
    sck = 1'b1;
    #40;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input logic lj, input int en_pos, input logic en_val);
    for (int i = 0; i < 2 * n; i++) begin
      logic ch, w, d;
      int   k;
      if (i == en_pos) en = en_val;
      ch = (i >= n);
      k  = ch ? i - n : i;
      d  = ch ? r[n-1-k] : l[n-1-k];
      if (lj) w = ch;
      else    w = (k == n - 1) ? ~ch : ch;
      send_bit(w, d);
    end
  endtask

  // first left bit of the next frame: commits the pending right slot
  task automatic send_trailer();
    send_bit(1'b0, 1'b0);
    #200;
  endtask

  int b_x16, b_e16, b_b16, b_x24, b_e24;

  task automatic snap();
    b_x16 = xfc16_n;
    b_e16 = err16_n;
    b_b16 = both16_n;
    b_x24 = xfc24_n;
    b_e24 = err24_n;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_lft16", 32'(lft16), 32'h0);
    check("rst_rgt16", 32'(rgt16), 32'h0);
    check("rst_xfc16", 32'(xfc16), 32'h0);
    check("rst_err16", 32'(err16), 32'h0);
    check("rst_act16", 32'(act16), 32'h0);
    check("rst_lft24", 32'(lft24), 32'h0);
    check("rst_act24", 32'(act24), 32'h0);
    rst = 1'b0;

    // I2S, 16-bit slots; mode pin toggled mid-run must be ignored
    en = 1'b1;
    snap();
    send_frame(32'hA5C3, 32'h3C5A, 16, 1'b0, -1, 1'b0);
    send_frame(32'hA5C3, 32'h3C5A, 16, 1'b0, -1, 1'b0);
    mode = 1'b1;
    send_frame(32'hA5C3, 32'h3C5A, 16, 1'b0, -1, 1'b0);
    send_frame(32'hA5C3, 32'h3C5A, 16, 1'b0, -1, 1'b0);
    send_trailer();
    check("i2s_xfc_cnt", 32'(xfc16_n - b_x16), 32'd3);
    check("i2s_err_cnt", 32'(err16_n - b_e16), 32'd0);
    check("i2s_lft", 32'(lft16), 32'hA5C3);
    check("i2s_rgt", 32'(rgt16), 32'h3C5A);
    check("i2s_active", 32'(act16), 32'h1);

    // LJ, 24-bit samples in 32-bit slots with nonzero trailing bits
    en = 1'b0;
    mode = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    snap();
    send_frame(32'h123456FF, 32'hFEDCBAA5, 32, 1'b1, -1, 1'b0);
    send_frame(32'h123456FF, 32'hFEDCBAA5, 32, 1'b1, -1, 1'b0);
    send_frame(32'h123456FF, 32'hFEDCBAA5, 32, 1'b1, -1, 1'b0);
    send_trailer();
    check("lj_xfc_cnt", 32'(xfc24_n - b_x24), 32'd2);
    check("lj_err_cnt", 32'(err24_n - b_e24), 32'd0);
    check("lj_lft", 32'(lft24), 32'h123456);
    check("lj_rgt", 32'(rgt24), 32'hFEDCBA);

    // I2S, 12-bit slots into the 16-bit receiver
    en = 1'b0;
    mode = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    snap();
    for (int f = 0; f < 4; f++) send_frame(32'hABC, 32'h123, 12, 1'b0, -1, 1'b0);
    send_trailer();
    check("short_xfc_cnt", 32'(xfc16_n - b_x16), 32'd3);
    check("short_err_cnt", 32'(err16_n - b_e16), 32'd6);
    check("short_err_with_xfc", 32'(both16_n - b_b16), 32'd3);
    check("short_lft", 32'(lft16), 32'hABC0);
    check("short_rgt", 32'(rgt16), 32'h1230);

    // enable arrives in the middle of a right slot
    en = 1'b0;
    repeat (5) @(negedge clk);
    snap();
    send_frame(32'h5555, 32'hAAAA, 16, 1'b0, 24, 1'b1);
    send_frame(32'h0F0F, 32'hF00F, 16, 1'b0, -1, 1'b0);
    check("late_en_no_xfc", 32'(xfc16_n - b_x16), 32'd0);
    send_trailer();
    check("late_en_xfc_cnt", 32'(xfc16_n - b_x16), 32'd1);
    check("late_en_lft", 32'(lft16), 32'h0F0F);
    check("late_en_rgt", 32'(rgt16), 32'hF00F);

    // disable mid-left, two idle frames, then re-enable
    snap();
    send_frame(32'h1234, 32'h5678, 16, 1'b0, 8, 1'b0);
    send_frame(32'h1234, 32'h5678, 16, 1'b0, -1, 1'b0);
    send_frame(32'h1234, 32'h5678, 16, 1'b0, -1, 1'b0);
    check("dis_no_xfc", 32'(xfc16_n - b_x16), 32'd0);
    check("dis_hold_lft", 32'(lft16), 32'h0F0F);
    check("dis_hold_rgt", 32'(rgt16), 32'hF00F);
    check("dis_active", 32'(act16), 32'h0);
    send_frame(32'h1234, 32'h5678, 16, 1'b0, 0, 1'b1);
    send_frame(32'h8001, 32'h7FFE, 16, 1'b0, -1, 1'b0);
    send_trailer();
    check("reen_xfc_cnt", 32'(xfc16_n - b_x16), 32'd1);
    check("reen_lft", 32'(lft16), 32'h8001);
    check("reen_rgt", 32'(rgt16), 32'h7FFE);

    // synchronous reset while running, with enable still high
    @(negedge clk);
    check("pre_rst_active", 32'(act16), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_lft16", 32'(lft16), 32'h0);
    check("mid_rst_rgt16", 32'(rgt16), 32'h0);
    check("mid_rst_act16", 32'(act16), 32'h0);
    check("mid_rst_xfc16", 32'(xfc16), 32'h0);
    check("mid_rst_lft24", 32'(lft24), 32'h0);
    check("mid_rst_act24", 32'(act24), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_act16", 32'(act16), 32'h0);

    check("xfc_consecutive", 32'(consec_n), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2si_frame_rx.md
# i2si_frame_rx

Parametrised I2S receiver, successor to the 16-bit fixed deserializer. Oversamples asynchronous SCK/WS/SD in the system clock domain and tracks slots by sampled WS. Supports Philips I2S and left-justified framing, with configurable sample width. Delivers one aligned stereo pair per frame with a single-cycle transfer strobe and a slot-length error flag; sits between the I2S input pads and the audio register file / FIFO.

## Interface
Parameters:
- DATA_W, 16, sample width per channel (8..32)
- CNT_W, 6, slot bit-counter width; counter saturates at 2^CNT_W-1
- SYNC_STAGES, 2, flip-flop stages on each async input (>=2)

Ports:
- clk  in  1  system clock; must be >= 4x SCK frequency
- rst  in  1  synchronous, active-high reset
- rf_i2si_en  in  1  receiver enable; low forces IDLE
- rf_i2si_mode  in  1  0 = Philips I2S (MSB one SCK after WS edge), 1 = left-justified
- i2si_sck  in  1  async serial bit clock
- i2si_ws  in  1  async word select; 0 = left, 1 = right
- i2si_sd  in  1  async serial data, MSB first
- i2si_lft  out  DATA_W  last complete left sample
- i2si_rgt  out  DATA_W  last complete right sample
- i2si_xfc  out  1  one-clk pulse: i2si_lft/i2si_rgt updated with a new pair
- i2si_err  out  1  one-clk pulse: a committed slot had fewer than DATA_W bits
- i2si_active  out  1  high in RUN state

## Operation
- Synchronise sck, ws, sd through SYNC_STAGES flops; sck_rise = synced sck 0->1 (previous value registered).
- On each sck_rise, sample ws_s and sd_s. Channel of the sampled bit: I2S mode = ws sampled at the previous sck_rise; LJ mode = current ws_s.
- Slot boundary: channel of the current bit differs from the channel of the previous bit. At a boundary, commit the finished slot, clear the bit counter and shift register, then shift in the current bit as MSB of the new slot.
- Shift: the first DATA_W bits of a slot enter MSB-first; further bits are ignored; counter saturates.
- Commit of a short slot (count < DATA_W): left-align received bits, zero-fill LSBs, pulse i2si_err.
- Left commit -> pending-left register. Right commit -> i2si_lft <= pending-left, i2si_rgt <= right word, pulse i2si_xfc.
- State machine:
  - IDLE: entered on rst or rf_i2si_en=0. Latches rf_i2si_mode. Exits to SYNC when enabled.
  - SYNC: discards bits until the first right->left boundary, then goes to RUN with that bit as left MSB.
  - RUN: normal operation.
- Mode changes while not in IDLE are ignored until the next enable.
- Disable mid-frame: IDLE on the next clk. Partial slot and pending-left are discarded. Outputs hold; no xfc.
- Re-enable always passes through SYNC. The first xfc requires a full left+right after sync.

## Timing
- Reset values: i2si_lft=0, i2si_rgt=0, i2si_xfc=0, i2si_err=0, i2si_active=0, state=IDLE, counters/shift/pending cleared.
- Pin-to-sck_rise detection: SYNC_STAGES+1 clk.
- Commit: the right slot commits on the sck_rise carrying the first left bit of the next frame. i2si_xfc and the new outputs appear 1 clk after that sck_rise detection.
- i2si_err coincides with the commit cycle of the offending slot. For a short right slot it coincides with i2si_xfc.
- i2si_xfc is never asserted on consecutive clks.
- rst has priority over rf_i2si_en.

## Structure
- Package i2si_pkg:
  - state enum: IDLE, SYNC, RUN
  - mode constants: MODE_I2S=1'b0, MODE_LJ=1'b1
  - channel constants: CH_LEFT=1'b0, CH_RIGHT=1'b1
- Sub-module i2si_sync_edge: SYNC_STAGES synchroniser plus registered rising-edge detect. Instantiated for sck (edge used) and for ws and sd (level only).
- Top: state machine, slot counter, shift register, commit/output registers.

## Test plan
- I2S mode, DATA_W=16, 16 SCK/slot, L=0xA5C3, R=0x3C5A, clk=8x SCK -> after sync, one xfc per frame with i2si_lft=0xA5C3, i2si_rgt=0x3C5A; err never asserted.
- LJ mode, DATA_W=24, 32 SCK/slot, L=0x123456, R=0xFEDCBA -> xfc with i2si_lft=0x123456, i2si_rgt=0xFEDCBA; trailing 8 bits ignored.
- I2S, DATA_W=16, 12-bit slots, L bits=0xABC, R bits=0x123 -> i2si_lft=0xABC0, i2si_rgt=0x1230; err pulses on both commits, the second with xfc.
- Enable asserted mid-right slot -> no xfc until one full L+R completes; first pair correct.
- rf_i2si_en dropped mid-left slot, re-enabled 2 frames later -> outputs hold the old pair during disable; no spurious xfc; the next pair is correct.
- rst asserted mid-frame while in RUN -> all outputs 0 on the next clk, state IDLE, i2si_active=0.
